// File: rtl/eth_std_main_system_cpu_cpu_debug_monitor_ctrl.sv
// CPU debug monitor: turns JTAG debug-slave commands into single Avalon-MM
// reads/writes to the debug RAM, with a timeout and a dropped-command error flag.
module eth_std_main_system_cpu_cpu_debug_monitor_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [37:0] jdo,
  input  logic        take_action_ocimem_a,
  input  logic        take_action_ocimem_b,
  input  logic        take_no_action_ocimem_a,
  output logic [9:0]  avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic [31:0] MonDReg,
  output logic [9:0]  MonAReg,
  output logic        monitor_ready,
  output logic        monitor_error
);

  localparam int unsigned AW = 10;
  localparam int unsigned TW = 8;

  typedef enum logic [1:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ} state_t;

  state_t        state;
  logic [TW-1:0] tcount;
  logic          inc_after_rd;
  logic          any_cmd;
  logic          unused_jdo;

  assign any_cmd     = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign unused_jdo  = ^{jdo[37:35], jdo[2:0]};
  // MonAReg only moves on accept/completion, so it is stable for the whole request.
  assign avm_address = MonAReg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      tcount        <= '0;
      inc_after_rd  <= 1'b0;
      MonDReg       <= '0;
      MonAReg       <= '0;
      avm_read      <= 1'b0;
      avm_write     <= 1'b0;
      avm_writedata <= '0;
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
    end else if (state == IDLE) begin
      if (take_action_ocimem_b) begin
        MonDReg       <= jdo[34:3];
        avm_writedata <= jdo[34:3];
        avm_write     <= 1'b1;
        inc_after_rd  <= 1'b0;
        tcount        <= '0;
        monitor_ready <= 1'b0;
        monitor_error <= 1'b0;
        state         <= WR_REQ;
      end else if (take_action_ocimem_a) begin
        MonAReg       <= {jdo[33:26], 2'b00};
        inc_after_rd  <= 1'b0;
        tcount        <= '0;
        monitor_ready <= ~jdo[25];
        monitor_error <= 1'b0;
        if (jdo[25]) begin
          avm_read <= 1'b1;
          state    <= RD_REQ;
        end
      end else if (take_no_action_ocimem_a) begin
        avm_read      <= 1'b1;
        inc_after_rd  <= 1'b1;
        tcount        <= '0;
        monitor_ready <= 1'b0;
        monitor_error <= 1'b0;
        state         <= RD_REQ;
      end
    end else begin
      // Commands arriving while busy are dropped but remembered as an error.
      if (any_cmd) monitor_error <= 1'b1;
      if (tcount == {TW{1'b1}}) begin
        avm_read      <= 1'b0;
        avm_write     <= 1'b0;
        monitor_error <= 1'b1;
        monitor_ready <= 1'b1;
        state         <= IDLE;
      end else begin
        tcount <= tcount + TW'(1);
        case (state)
          RD_REQ: begin
            if (!avm_waitrequest) begin
              avm_read <= 1'b0;
              state    <= RD_WAIT;
            end
          end
          RD_WAIT: begin
            if (avm_readdatavalid) begin
              MonDReg       <= avm_readdata;
              monitor_ready <= 1'b1;
              state         <= IDLE;
              if (inc_after_rd) MonAReg <= MonAReg + AW'(4);
            end
          end
          WR_REQ: begin
            if (!avm_waitrequest) begin
              avm_write     <= 1'b0;
              monitor_ready <= 1'b1;
              MonAReg       <= MonAReg + AW'(4);
              state         <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_eth_std_main_system_cpu_cpu_debug_monitor_ctrl.sv
// Bench for the debug monitor: a wait-state Avalon slave, a bus scoreboard
// of expected transactions and register checks after each command.
module tb_eth_std_main_system_cpu_cpu_debug_monitor_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [37:0] jdo = '0;
  logic        take_action_ocimem_a = 1'b0;
  logic        take_action_ocimem_b = 1'b0;
  logic        take_no_action_ocimem_a = 1'b0;
  logic [9:0]  avm_address;
  logic        avm_read, avm_write;
  logic [31:0] avm_writedata;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata = '0;
  logic        avm_readdatavalid = 1'b0;
  logic [31:0] MonDReg;
  logic [9:0]  MonAReg;
  logic        monitor_ready, monitor_error;

  eth_std_main_system_cpu_cpu_debug_monitor_ctrl dut (
    .clk(clk), .reset(reset), .jdo(jdo),
    .take_action_ocimem_a(take_action_ocimem_a),
    .take_action_ocimem_b(take_action_ocimem_b),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
    .MonDReg(MonDReg), .MonAReg(MonAReg),
    .monitor_ready(monitor_ready), .monitor_error(monitor_error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wr;
    logic [9:0]  addr;
    logic [31:0] data;
  } txn_t;

  txn_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          strobe_cnt = 0;
  bit          slave_en = 1'b1;
  int          ws_cfg = 0;
  int          ws_cnt = 0;
  bit          pend_rd = 1'b0;
  logic [31:0] rd_data_cfg = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Bus monitor: every strobed cycle must match the head of the scoreboard,
  // which is retired when the slave accepts it.
  always @(negedge clk) begin
    if (avm_read || avm_write) begin
      strobe_cnt++;
      if (avm_read && avm_write) check("both_strobes", 64'(1), 64'(0));
      if (exp_q.size() == 0) begin
        check("unexpected_txn", {53'(0), avm_write, avm_address}, 64'h7FF);
      end else begin
        check("bus_txn", 64'({avm_write, avm_address, avm_write ? avm_writedata : 32'h0}),
              64'(exp_q[0]));
        if (!avm_waitrequest) void'(exp_q.pop_front());
      end
    end
  end

  // Slave: ws_cfg wait states per strobe, read data one cycle after acceptance.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (slave_en) begin
        avm_readdatavalid = pend_rd;
        avm_readdata      = pend_rd ? rd_data_cfg : 32'h0;
        pend_rd           = 1'b0;
        if (avm_read || avm_write) begin
          if (ws_cnt < ws_cfg) begin
            avm_waitrequest = 1'b1;
            ws_cnt++;
          end else begin
            avm_waitrequest = 1'b0;
            ws_cnt  = 0;
            pend_rd = avm_read;
          end
        end else begin
          avm_waitrequest = 1'b0;
          ws_cnt = 0;
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pulse_a(input logic [7:0] a, input logic rd);
    jdo = '0;
    jdo[33:26] = a;
    jdo[25] = rd;
    take_action_ocimem_a = 1'b1;
    cyc(1);
    take_action_ocimem_a = 1'b0;
  endtask

  task automatic pulse_b(input logic [31:0] d);
    jdo = '0;
    jdo[34:3] = d;
    take_action_ocimem_b = 1'b1;
    cyc(1);
    take_action_ocimem_b = 1'b0;
  endtask

  task automatic pulse_na();
    take_no_action_ocimem_a = 1'b1;
    cyc(1);
    take_no_action_ocimem_a = 1'b0;
  endtask

  task automatic wait_ready(input int budget);
    int n = 0;
    while (!monitor_ready && n < budget) begin
      cyc(1);
      n++;
    end
    check("ready_wait", 64'(monitor_ready), 64'(1));
  endtask

  initial begin
    cyc(3);
    check("rst_mond", 64'(MonDReg), 64'(0));
    check("rst_mona", 64'(MonAReg), 64'(0));
    check("rst_strobes", 64'({avm_read, avm_write}), 64'(0));
    check("rst_wdata", 64'(avm_writedata), 64'(0));
    check("rst_flags", 64'({monitor_ready, monitor_error}), 64'(0));
    reset = 1'b0;
    cyc(2);

    // Addressed read of 0x040
    ws_cfg = 0;
    rd_data_cfg = 32'hCAFEBABE;
    exp_q.push_back('{wr: 1'b0, addr: 10'h040, data: 32'h0});
    pulse_a(8'h10, 1'b1);
    check("rd_ready_clr", 64'(monitor_ready), 64'(0));
    wait_ready(20);
    check("rd_mond", 64'(MonDReg), 64'hCAFEBABE);
    check("rd_mona", 64'(MonAReg), 64'h040);
    check("rd_err", 64'(monitor_error), 64'(0));
    check("rd_q_empty", 64'(exp_q.size()), 64'(0));

    // Address load only, then three post-incrementing reads
    pulse_a(8'h00, 1'b0);
    check("ld_ready", 64'(monitor_ready), 64'(1));
    check("ld_mona", 64'(MonAReg), 64'h000);
    for (int i = 0; i < 3; i++) begin
      rd_data_cfg = 32'h1000_0000 + 32'(i);
      exp_q.push_back('{wr: 1'b0, addr: 10'(4 * i), data: 32'h0});
      pulse_na();
      wait_ready(20);
      check("na_mond", 64'(MonDReg), 64'(32'h1000_0000 + 32'(i)));
      check("na_mona", 64'(MonAReg), 64'(4 * (i + 1)));
    end

    // Write at top of RAM with 3 wait states; address wraps to 0
    pulse_a(8'hFF, 1'b0);
    check("ld_top", 64'(MonAReg), 64'h3FC);
    ws_cfg = 3;
    exp_q.push_back('{wr: 1'b1, addr: 10'h3FC, data: 32'h12345678});
    pulse_b(32'h12345678);
    wait_ready(20);
    check("wr_mona_wrap", 64'(MonAReg), 64'h000);
    check("wr_mond", 64'(MonDReg), 64'h12345678);
    check("wr_err", 64'(monitor_error), 64'(0));
    check("wr_q_empty", 64'(exp_q.size()), 64'(0));

    // Read against a permanently stalled slave times out
    ws_cfg = 1000;
    exp_q.push_back('{wr: 1'b0, addr: 10'h080, data: 32'h0});
    strobe_cnt = 0;
    pulse_a(8'h20, 1'b1);
    wait_ready(400);
    cyc(2);
    check("to_strobe_cycles", 64'(strobe_cnt), 64'(256));
    check("to_read_low", 64'(avm_read), 64'(0));
    check("to_flags", 64'({monitor_ready, monitor_error}), 64'(3));
    check("to_mond", 64'(MonDReg), 64'h12345678);
    check("to_mona", 64'(MonAReg), 64'h080);
    check("to_pending", 64'(exp_q.size()), 64'(1));
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    ws_cfg = 0;
    cyc(2);

    // Collision: write wins, a later ocimem_a during the write is dropped
    ws_cfg = 2;
    jdo = '0;
    jdo[34:3] = 32'hA5A55A5A;
    take_action_ocimem_b = 1'b1;
    take_no_action_ocimem_a = 1'b1;
    exp_q.push_back('{wr: 1'b1, addr: 10'h080, data: 32'hA5A55A5A});
    cyc(1);
    take_action_ocimem_b = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    check("col_err_clr", 64'(monitor_error), 64'(0));
    pulse_a(8'h03, 1'b1);
    wait_ready(20);
    check("col_err", 64'(monitor_error), 64'(1));
    check("col_mona", 64'(MonAReg), 64'h084);
    check("col_mond", 64'(MonDReg), 64'hA5A55A5A);
    cyc(5);
    check("col_no_read", 64'(exp_q.size()), 64'(0));
    ws_cfg = 0;

    // Reset while waiting for read data, then stale data after release
    slave_en = 1'b0;
    avm_waitrequest = 1'b0;
    avm_readdatavalid = 1'b0;
    exp_q.push_back('{wr: 1'b0, addr: 10'h014, data: 32'h0});
    pulse_a(8'h05, 1'b1);
    cyc(1);
    check("rw_err_clr", 64'(monitor_error), 64'(0));
    check("rw_read_done", 64'(avm_read), 64'(0));
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    avm_readdata = 32'hFFFFFFFF;
    avm_readdatavalid = 1'b1;
    cyc(1);
    avm_readdatavalid = 1'b0;
    avm_readdata = 32'h0;
    cyc(2);
    check("rw_mond", 64'(MonDReg), 64'(0));
    check("rw_mona", 64'(MonAReg), 64'(0));
    check("rw_flags", 64'({monitor_ready, monitor_error}), 64'(0));
    check("rw_strobes", 64'({avm_read, avm_write}), 64'(0));
    check("rw_q_empty", 64'(exp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
